// File: rtl/prescaler_mc_pkg.sv
// Shared types and default sizing for the multi-channel prescaler.
package prescaler_lib;

  localparam int unsigned COUNTER_WIDTH = 32;
  localparam int unsigned CHANNELS      = 4;

  typedef enum logic {PSC_PULSE, PSC_SQUARE} psc_mode_t;

  typedef struct packed {
    logic [COUNTER_WIDTH-1:0] div;
    psc_mode_t                mode;
  } psc_cfg_t;

endpackage

// File: rtl/prescaler_ch.sv
// One prescaler channel: double-buffered divisor/mode, down-counter, tick and square outputs.
module prescaler_ch
  import prescaler_lib::*;
#(
  parameter int unsigned W = COUNTER_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         sync,
  input  logic         wr,
  input  logic [W-1:0] wr_div,
  input  psc_mode_t    wr_mode,
  output logic         tick,
  output logic         sq
);

  typedef struct packed {
    logic [W-1:0] div;
    psc_mode_t    mode;
  } cfg_t;

  localparam cfg_t RESET_CFG = '{div: W'(1), mode: PSC_PULSE};

  cfg_t         shadow_q, shadow_d, load_cfg;
  psc_mode_t    active_mode_q, active_mode_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;
  logic         sq_q, sq_d;

  // Reload value for a divisor: D==0 behaves like D==1.
  function automatic logic [W-1:0] reload(input logic [W-1:0] d);
    return (d == '0) ? '0 : d - W'(1);
  endfunction

  // The adopted divisor is consumed entirely by the counter reload, so only
  // the adopted mode needs its own register.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    shadow_d      = shadow_q;
    active_mode_d = active_mode_q;
    cnt_d         = cnt_q;
    tick_d        = 1'b0;
    sq_d          = sq_q;
    load_cfg      = wr ? cfg_t'{div: wr_div, mode: wr_mode} : shadow_q;

    if (wr) shadow_d = '{div: wr_div, mode: wr_mode};

    if (sync) begin
      active_mode_d = load_cfg.mode;
      cnt_d         = reload(load_cfg.div);
      sq_d          = 1'b0;
    end else if (en) begin
      if (cnt_q == '0) begin
        // Terminal count adopts the shadow as it stood before this cycle's write.
        tick_d        = 1'b1;
        active_mode_d = shadow_q.mode;
        cnt_d         = reload(shadow_q.div);
        sq_d          = (shadow_q.mode == PSC_SQUARE) ? ~sq_q : 1'b0;
      end else begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q      <= RESET_CFG;
      active_mode_q <= PSC_PULSE;
      cnt_q         <= '0;
      tick_q        <= 1'b0;
      sq_q          <= 1'b0;
    end else begin
      // NOTE: state registers update with <= so every flop samples pre-edge values.
      shadow_q      <= shadow_d;
      active_mode_q <= active_mode_d;
      cnt_q         <= cnt_d;
      tick_q        <= tick_d;
      sq_q          <= sq_d;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q && (active_mode_q == PSC_SQUARE);

endmodule

// File: rtl/prescaler_mc.sv
// Multi-channel programmable prescaler: decodes the shadow write and fans out to N channels.
module prescaler_mc #(
  parameter  int unsigned COUNTER_WIDTH = prescaler_lib::COUNTER_WIDTH,
  parameter  int unsigned CHANNELS      = prescaler_lib::CHANNELS,
  localparam int unsigned CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS-1:0]      en,
  input  logic                     sync,
  input  logic                     wr_en,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic [COUNTER_WIDTH-1:0] wr_div,
  input  logic                     wr_mode,
  output logic [CHANNELS-1:0]      tick,
  output logic [CHANNELS-1:0]      sq
);

  // Out-of-range channel numbers simply match no instance.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    prescaler_ch #(
      .W(COUNTER_WIDTH)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .sync    (sync),
      .wr      (wr_en && (wr_ch == CH_W'(i))),
      .wr_div  (wr_div),
      .wr_mode (prescaler_lib::psc_mode_t'(wr_mode)),
      .tick    (tick[i]),
      .sq      (sq[i])
    );
  end

endmodule

// File: tb/tb_prescaler_mc.sv
// Self-checking bench for prescaler_mc: directed vector table, timing sequences, randomized model compare.
module tb_prescaler_mc;

  localparam int W  = 8;
  localparam int N  = 3;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst, sync, wr_en, wr_mode;
  logic [N-1:0]  en;
  logic [CW-1:0] wr_ch;
  logic [W-1:0]  wr_div;
  logic [N-1:0]  tick, sq;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  prescaler_mc #(.COUNTER_WIDTH(W), .CHANNELS(N)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_div(wr_div), .wr_mode(wr_mode), .tick(tick), .sq(sq)
  );

  // Reference model: per-channel pending config, remaining count to terminal, outputs.
  int m_sh_div[N];
  bit m_sh_sq[N];
  int m_cnt[N];
  bit m_tick[N];
  bit m_sq[N];

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      bit wr_here;
      wr_here = wr_en && (int'(wr_ch) == i);
      if (rst) begin
        m_sh_div[i] = 1; m_sh_sq[i] = 0; m_cnt[i] = 0; m_tick[i] = 0; m_sq[i] = 0;
      end else begin
        if (sync) begin
          m_cnt[i]  = eff(wr_here ? int'(wr_div) : m_sh_div[i]) - 1;
          m_tick[i] = 0;
          m_sq[i]   = 0;
        end else if (en[i]) begin
          if (m_cnt[i] == 0) begin
            m_tick[i] = 1;
            m_cnt[i]  = eff(m_sh_div[i]) - 1;
            m_sq[i]   = m_sh_sq[i] ? !m_sq[i] : 1'b0;
          end else begin
            m_tick[i] = 0;
            m_cnt[i]  = m_cnt[i] - 1;
          end
        end else begin
          m_tick[i] = 0;
        end
        if (wr_here) begin
          m_sh_div[i] = int'(wr_div);
          m_sh_sq[i]  = wr_mode;
        end
      end
    end
  endtask

  function automatic logic [N-1:0] model_tick();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_tick[i];
    return v;
  endfunction

  function automatic logic [N-1:0] model_sq();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_sq[i];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rst = 0; sync = 0; wr_en = 0; wr_ch = '0; wr_div = '0; wr_mode = 0; en = '1;
  endtask

  // Apply current inputs across one rising edge, then settle past the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          rst;
    logic [N-1:0]  en;
    logic          sync;
    logic          wr_en;
    logic [CW-1:0] wr_ch;
    logic [W-1:0]  wr_div;
    logic          wr_mode;
    logic [N-1:0]  exp_tick;
    logic [N-1:0]  exp_sq;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [N-1:0] e, input logic s, input logic we,
                              input logic [CW-1:0] ch, input logic [W-1:0] d, input logic m,
                              input logic [N-1:0] et, input logic [N-1:0] es);
    vec_t v;
    v.rst = r; v.en = e; v.sync = s; v.wr_en = we; v.wr_ch = ch; v.wr_div = d; v.wr_mode = m;
    v.exp_tick = et; v.exp_sq = es;
    return v;
  endfunction

  vec_t vecs[21];

  initial begin
    idle_inputs();
    //           rst en      syn we  ch  div  m   tick    sq
    vecs[0]  = mk(1, 3'b111, 0, 0, 0, 0,  0, 3'b000, 3'b000);
    vecs[1]  = mk(0, 3'b111, 0, 0, 0, 0,  0, 3'b111, 3'b000);
    vecs[2]  = mk(0, 3'b111, 0, 0, 0, 0,  0, 3'b111, 3'b000);
    vecs[3]  = mk(0, 3'b111, 0, 1, 1, 2,  1, 3'b111, 3'b000);
    vecs[4]  = mk(0, 3'b111, 0, 0, 0, 0,  0, 3'b111, 3'b010);
    vecs[5]  = mk(0, 3'b111, 0, 0, 0, 0,  0, 3'b101, 3'b010);
    vecs[6]  = mk(0, 3'b111, 0, 0, 0, 0,  0, 3'b111, 3'b000);
    vecs[7]  = mk(0, 3'b111, 0, 0, 0, 0,  0, 3'b101, 3'b000);
    vecs[8]  = mk(0, 3'b111, 0, 0, 0, 0,  0, 3'b111, 3'b010);
    vecs[9]  = mk(0, 3'b101, 0, 0, 0, 0,  0, 3'b101, 3'b010);
    vecs[10] = mk(0, 3'b111, 0, 0, 0, 0,  0, 3'b101, 3'b010);
    vecs[11] = mk(0, 3'b111, 0, 0, 0, 0,  0, 3'b111, 3'b000);
    vecs[12] = mk(0, 3'b111, 0, 1, 3, 9,  0, 3'b101, 3'b000);
    vecs[13] = mk(0, 3'b111, 0, 0, 0, 0,  0, 3'b111, 3'b010);
    vecs[14] = mk(0, 3'b111, 1, 1, 0, 3,  0, 3'b000, 3'b000);
    vecs[15] = mk(0, 3'b111, 0, 0, 0, 0,  0, 3'b100, 3'b000);
    vecs[16] = mk(0, 3'b111, 0, 0, 0, 0,  0, 3'b110, 3'b010);
    vecs[17] = mk(0, 3'b111, 0, 0, 0, 0,  0, 3'b101, 3'b010);
    vecs[18] = mk(1, 3'b111, 0, 1, 0, 5,  0, 3'b000, 3'b000);
    vecs[19] = mk(0, 3'b111, 0, 0, 0, 0,  0, 3'b111, 3'b000);
    vecs[20] = mk(0, 3'b111, 0, 0, 0, 0,  0, 3'b111, 3'b000);

    @(negedge clk);
    for (int v = 0; v < 21; v++) begin
      rst = vecs[v].rst; en = vecs[v].en; sync = vecs[v].sync; wr_en = vecs[v].wr_en;
      wr_ch = vecs[v].wr_ch; wr_div = vecs[v].wr_div; wr_mode = vecs[v].wr_mode;
      cycle();
      check($sformatf("vec%0d.tick", v), 32'(tick), 32'(vecs[v].exp_tick));
      check($sformatf("vec%0d.sq", v), 32'(sq), 32'(vecs[v].exp_sq));
    end

    // D=4 PULSE on ch0 via sync, then D=10 written two cycles before a terminal count.
    idle_inputs(); rst = 1; cycle();
    idle_inputs(); wr_en = 1; wr_ch = 0; wr_div = 4; cycle();
    idle_inputs(); sync = 1; cycle();
    idle_inputs();
    for (int o = 1; o <= 30; o++) begin
      if (o == 14) begin wr_en = 1; wr_ch = 0; wr_div = 10; end
      cycle();
      wr_en = 0;
      check($sformatf("div_change.o%0d.tick0", o), 32'(tick[0]),
            32'(o == 4 || o == 8 || o == 12 || o == 16 || o == 26));
      check($sformatf("div_change.o%0d.tick2", o), 32'(tick[2]), 32'd1);
    end

    // en[0] held low for 5 edges mid-period adds exactly 5 cycles of delay.
    idle_inputs(); sync = 1; cycle();
    idle_inputs();
    for (int o = 1; o <= 36; o++) begin
      en[0] = !(o >= 13 && o <= 17);
      cycle();
      check($sformatf("en_hold.o%0d.tick0", o), 32'(tick[0]),
            32'(o == 10 || o == 25 || o == 35));
    end

    // ch1 D=3 SQUARE: tick every 3, sq period 6.
    idle_inputs(); wr_en = 1; wr_ch = 1; wr_div = 3; wr_mode = 1; sync = 1; cycle();
    idle_inputs();
    for (int o = 1; o <= 12; o++) begin
      cycle();
      check($sformatf("square.o%0d.tick1", o), 32'(tick[1]), 32'(o % 3 == 0));
      check($sformatf("square.o%0d.sq1", o), 32'(sq[1]), 32'((o / 3) % 2 == 1));
      check($sformatf("square.o%0d.sq0", o), 32'(sq[0]), 32'd0);
    end

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      rst     = ($urandom_range(0, 99) == 0);
      sync    = ($urandom_range(0, 29) == 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_ch   = CW'($urandom_range(0, 3));
      wr_div  = ($urandom_range(0, 9) == 0) ? W'($urandom_range(200, 255)) : W'($urandom_range(0, 6));
      wr_mode = 1'($urandom_range(0, 1));
      en      = ($urandom_range(0, 4) == 0) ? N'($urandom) : '1;
      cycle();
      check($sformatf("rand%0d.tick", c), 32'(tick), 32'(model_tick()));
      check($sformatf("rand%0d.sq", c), 32'(sq), 32'(model_sq()));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/prescaler_mc.md
# prescaler_mc

Multi-channel programmable prescaler: CHANNELS independent down-counters, each dividing the system clock by a runtime-loaded divisor and producing either a one-cycle tick or a square wave. Divisor and mode changes are double-buffered and take effect only at a channel's terminal count, so output periods never glitch. A global sync re-aligns all channel phases. The block serves as the shared timebase generator for downstream timing logic.

## Interface
- COUNTER_WIDTH, 32: counter/divisor width W
- CHANNELS, 4: number of channels N (1..32)
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- en  in  N  per-channel run enable; counter holds while low
- sync  in  1  realign all channels (see Operation)
- wr_en  in  1  shadow-register write strobe
- wr_ch  in  max(1,$clog2(N))  target channel; values >= N ignored
- wr_div  in  W  divisor D
- wr_mode  in  1  0 = PULSE, 1 = SQUARE
- tick  out  N  registered one-cycle terminal pulse per channel
- sq  out  N  registered square output (SQUARE mode only, else 0)

## Operation
- Per channel: shadow {div, mode}, active {div, mode}, counter cnt[W-1:0], tick, sq.
- Effective divisor eff(D) = 1 if D==0, else D. Max D = 2^W-1.
- Reset: shadow.div = active.div = 1, modes = PULSE, cnt = 0, tick = 0, sq = 0.
- wr_en with valid wr_ch: shadow of that channel <= {wr_div, wr_mode}. Active unchanged.
- Each edge, en[i]=1, no sync:
  - cnt==0: tick <= 1; active <= shadow (pre-write value if written this cycle); cnt <= eff(new active.div)-1; if new mode SQUARE, sq <= ~sq, else sq <= 0.
  - cnt!=0: tick <= 0; cnt <= cnt-1.
- en[i]=0: cnt, sq, active hold; tick <= 0.
- sync (priority over counting, ignores en): every channel active <= shadow, cnt <= eff(shadow.div)-1, tick <= 0, sq <= 0. If wr_en in the same cycle, the written channel uses wr_div/wr_mode (write bypass).
- rst has priority over sync and wr_en.

## Timing
- PULSE: tick period = eff(D) cycles; D in {0,1} gives tick every cycle (tick stays high).
- SQUARE: sq toggles on every tick; period 2·eff(D), 50% duty.
- After sync at edge k with D: first tick high after edge k+D, then every D.
- After reset with en high: first tick after the first edge (cnt=0), then period 1 until a new divisor is adopted.
- Divisor write latency: adopted at the channel's next terminal count, never mid-period.
- Outputs registered; no combinational input-to-output path.
- Mid-period rst: all outputs 0 on the next cycle, counters restart as from reset.

## Structure
- Package prescaler_lib: COUNTER_WIDTH, CHANNELS defaults; typedef enum logic {PSC_PULSE, PSC_SQUARE} psc_mode_t; typedef struct packed {logic [COUNTER_WIDTH-1:0] div; psc_mode_t mode;} psc_cfg_t.
- Sub-module prescaler_ch: one channel (shadow, active, cnt, tick, sq); inputs en, sync, wr (decoded per channel), cfg. Top prescaler_mc decodes wr_ch and generates N instances.

## Test plan
- Reset, en=all 1, no writes -> tick=1 every cycle on all channels, sq=0.
- Write ch0 D=4 PULSE, then sync at edge k -> ch0 tick high after edges k+4, k+8, k+12; others period 1.
- Write ch1 D=3 SQUARE + sync -> sq[1] toggles every 3 cycles (period 6); tick[1] every 3.
- Ch0 running D=4, write D=10 two cycles before terminal -> one more period of 4, then period 10; no short period.
- en[0] low for 5 cycles mid-period -> tick[0] 0, phase resumes where held; extra 5-cycle delay exactly.
- wr_ch=N (invalid) with D=7 -> no channel changes; rst asserted mid-count -> all tick/sq 0 next cycle.
